control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have no parameters; all widths fixed.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 op  in  7  instruction opcode: lw 0000011, sw 0100011, R-type 0110011, I-type ALU 0010011, beq 1100011, jal 1101111.
REQ-005 funct3  in  3  instruction funct3.
REQ-006 funct7b5  in  1  instruction bit 30.
REQ-007 Zero  in  1  ALU zero flag.
REQ-008 ImmSrc  out  2  immediate format select.
REQ-009 ALUSrcA  out  2  ALU A select: 00 PC, 01 OldPC, 10 rs1 data.
REQ-010 ALUSrcB  out  2  ALU B select: 00 rs2 data, 01 ImmExt, 10 constant 4.
REQ-011 ResultSrc  out  2  result select: 00 ALUOut, 01 Data, 10 ALUResult.
REQ-012 AdrSrc  out  1  memory address select: 0 PC, 1 Result.
REQ-013 ALUControl  out  3  ALU operation code.
REQ-014 IRWrite, PCWrite, RegWrite, MemWrite  out  1 each  register and memory write enables.

Function
REQ-015 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL; one transition per clock.
REQ-016 SHALL implement these transitions:
- FETCH->DECODE.
- DECODE: lw/sw->MEMADR; R->EXECUTER; I->EXECUTEI; beq->BEQ; jal->JAL; any other op->FETCH.
- MEMADR: lw->MEMREAD; sw->MEMWRITE; otherwise->FETCH.
- MEMREAD->MEMWB->FETCH; MEMWRITE->FETCH.
- EXECUTER/EXECUTEI->ALUWB; JAL->ALUWB; ALUWB->FETCH; BEQ->FETCH.
REQ-017 SHALL drive these per-state outputs; every output not listed is 0:
- FETCH: AdrSrc 0, IRWrite 1, ALUSrcA 00, ALUSrcB 10, ALUOp 00, ResultSrc 10, PCUpdate 1.
- DECODE: ALUSrcA 01, ALUSrcB 01, ALUOp 00.
- MEMADR: ALUSrcA 10, ALUSrcB 01, ALUOp 00.
- MEMREAD: ResultSrc 00, AdrSrc 1.
- MEMWB: ResultSrc 01, RegWrite 1.
- MEMWRITE: ResultSrc 00, AdrSrc 1, MemWrite 1.
- EXECUTER: ALUSrcA 10, ALUSrcB 00, ALUOp 10.
- EXECUTEI: ALUSrcA 10, ALUSrcB 01, ALUOp 10.
- ALUWB: ResultSrc 00, RegWrite 1.
- BEQ: ALUSrcA 10, ALUSrcB 00, ALUOp 01, ResultSrc 00, Branch 1.
- JAL: ALUSrcA 01, ALUSrcB 10, ALUOp 00, ResultSrc 00, PCUpdate 1.
REQ-018 SHALL compute PCWrite = PCUpdate OR (Branch AND Zero), combinationally, so Zero affects PCWrite in the same cycle.
REQ-019 SHALL decode ImmSrc combinationally from op in all states: lw/I-type 00, sw 01, beq 10, jal 11, all other ops 00.
REQ-020 SHALL decode ALUControl combinationally:
- ALUOp 00 -> 000 (add); ALUOp 01 -> 001 (sub).
- ALUOp 10 with funct3 000 -> 001 if op[5] and funct7b5 are both 1, else 000.
- ALUOp 10 with funct3 010 -> 101 (slt); 110 -> 011 (or); 111 -> 010 (and); any other funct3 -> 000.
REQ-021 ALUOp and Branch SHALL be internal; outputs SHALL never be X or Z after reset.

Reset
REQ-022 With reset=0 at a rising clk edge, state SHALL become FETCH; while reset is held low, outputs SHALL equal the FETCH outputs.
REQ-023 Reset asserted mid-instruction SHALL abandon the instruction and return to FETCH on that edge.

Configuration
REQ-024 With macro CONTROL_UNIT_BNE_EN defined, in BEQ PCWrite SHALL equal Zero when funct3=000 and NOT Zero when funct3=001. Without the macro, PCWrite in BEQ SHALL equal Zero regardless of funct3.

Verification
REQ-025 Reset then lw (op 0000011): 5 cycles FETCH, DECODE, MEMADR, MEMREAD, MEMWB; MEMWB gives ResultSrc 01, RegWrite 1, ImmSrc 00.
REQ-026 sw (op 0100011): in MEMWRITE, MemWrite 1, AdrSrc 1, ImmSrc 01; returns to FETCH after 4 cycles.
REQ-027 R-type sub (funct3 000, funct7b5 1): EXECUTER gives ALUControl 001; same fields with op 0010011 give 000 in EXECUTEI.
REQ-028 beq with Zero=1 -> PCWrite 1, ALUControl 001; Zero=0 -> PCWrite 0; next state FETCH.
REQ-029 jal (op 1101111): JAL state gives PCWrite 1, ALUSrcA 01, ALUSrcB 10, ImmSrc 11, then ALUWB with RegWrite 1.
REQ-030 reset=0 asserted during MEMREAD -> next cycle is FETCH with IRWrite 1, PCWrite 1.

Source files
------------

// File: rtl/control_unit.sv
// Multicycle RISC-V control unit: Moore FSM plus combinational ALU/immediate decode.
// Optional CONTROL_UNIT_BNE_EN: the BEQ state also resolves bne (funct3=001).
module control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       AdrSrc,
    output logic [2:0] ALUControl,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite
);
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTER, EXECUTEI, ALUWB, BEQ, JAL
    } state_t;

    state_t     state, state_next, cur;
    logic [1:0] alu_op;
    logic       branch, pc_update, taken;

    always_ff @(posedge clk) begin
        if (!reset) state <= FETCH;
        else        state <= state_next;
    end

    // While reset is low the outputs already show FETCH, even before the first edge.
    assign cur = reset ? state : FETCH;

    always_comb begin
        state_next = FETCH;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        alu_op     = 2'b00;
        branch     = 1'b0;
        pc_update  = 1'b0;
        case (cur)
            FETCH: begin
                state_next = DECODE;
                IRWrite    = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                pc_update  = 1'b1;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_R:         state_next = EXECUTER;
                    OP_I:         state_next = EXECUTEI;
                    OP_BEQ:       state_next = BEQ;
                    OP_JAL:       state_next = JAL;
                    default:      state_next = FETCH;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                if (op == OP_LW)      state_next = MEMREAD;
                else if (op == OP_SW) state_next = MEMWRITE;
            end
            MEMREAD: begin
                state_next = MEMWB;
                AdrSrc     = 1'b1;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            EXECUTER: begin
                state_next = ALUWB;
                ALUSrcA    = 2'b10;
                alu_op     = 2'b10;
            end
            EXECUTEI: begin
                state_next = ALUWB;
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                alu_op     = 2'b10;
            end
            ALUWB: RegWrite = 1'b1;
            BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                branch  = 1'b1;
            end
            JAL: begin
                state_next = ALUWB;
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                pc_update  = 1'b1;
            end
            default: state_next = FETCH;
        endcase
    end

`ifdef CONTROL_UNIT_BNE_EN
    assign taken = (funct3 == 3'b001) ? ~Zero : Zero;
`else
    assign taken = Zero;
`endif
    assign PCWrite = pc_update | (branch & taken);

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end
endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed instructions then random ones, each cycle's
// outputs compared with a per-instruction step model.
module tb_control_unit;
    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic [1:0] ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
    logic       AdrSrc;
    logic [2:0] ALUControl;
    logic       IRWrite, PCWrite, RegWrite, MemWrite;

    int checks = 0;
    int errors = 0;
    string path[$];

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111,
                           BAD = 7'b0110111;

    control_unit dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .AdrSrc(AdrSrc), .ALUControl(ALUControl),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    // {ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl, IRWrite, PCWrite, RegWrite, MemWrite}
    function automatic logic [17:0] model(string st, logic [6:0] o, logic [2:0] f3, logic f7, logic z);
        logic [1:0] imm, a, b, rs;
        logic [2:0] alu;
        logic       adr, irw, pcw, rw, mw;
        imm = (o == SW) ? 2'd1 : (o == BQ) ? 2'd2 : (o == JL) ? 2'd3 : 2'd0;
        a = 0; b = 0; rs = 0; alu = 0; adr = 0; irw = 0; pcw = 0; rw = 0; mw = 0;
        if (st == "FETCH") begin irw = 1; b = 2; rs = 2; pcw = 1; end
        else if (st == "DECODE") begin a = 1; b = 1; end
        else if (st == "MEMADR") begin a = 2; b = 1; end
        else if (st == "MEMREAD") adr = 1;
        else if (st == "MEMWB") begin rs = 1; rw = 1; end
        else if (st == "MEMWRITE") begin adr = 1; mw = 1; end
        else if (st == "EXECUTER" || st == "EXECUTEI") begin
            a = 2;
            b = (st == "EXECUTEI") ? 2'd1 : 2'd0;
            if (f3 == 3'b000)      alu = (o == RT && f7) ? 3'd1 : 3'd0;
            else if (f3 == 3'b010) alu = 3'd5;
            else if (f3 == 3'b110) alu = 3'd3;
            else if (f3 == 3'b111) alu = 3'd2;
        end
        else if (st == "ALUWB") rw = 1;
        else if (st == "BEQ") begin
            a = 2; alu = 1;
`ifdef CONTROL_UNIT_BNE_EN
            pcw = (f3 == 3'b001) ? !z : z;
`else
            pcw = z;
`endif
        end
        else if (st == "JAL") begin a = 1; b = 2; pcw = 1; end
        return {imm, a, b, rs, adr, alu, irw, pcw, rw, mw};
    endfunction

    task automatic build_path(input logic [6:0] o);
        path = {"FETCH", "DECODE"};
        case (o)
            LW: path = {path, "MEMADR", "MEMREAD", "MEMWB"};
            SW: path = {path, "MEMADR", "MEMWRITE"};
            RT: path = {path, "EXECUTER", "ALUWB"};
            IT: path = {path, "EXECUTEI", "ALUWB"};
            BQ: path = {path, "BEQ"};
            JL: path = {path, "JAL", "ALUWB"};
            default: ;
        endcase
    endtask

    task automatic check(input string tag);
        logic [17:0] obs, exp;
        obs = {ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
               IRWrite, PCWrite, RegWrite, MemWrite};
        exp = model(tag, op, funct3, funct7b5, Zero);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s op=%b f3=%b obs=%h exp=%h", tag, op, funct3, obs, exp);
        end
    endtask

    // Entered at a negedge with the DUT in FETCH; leaves at the next FETCH negedge.
    // zsel 0/1 forces Zero, 2 randomizes; rst_at aborts with a reset at that step.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input int zsel, input int rst_at);
        op = o; funct3 = f3; funct7b5 = f7;
        build_path(o);
        foreach (path[i]) begin
            Zero = (zsel < 2) ? zsel[0] : 1'($urandom % 2);
            #1;
            check(path[i]);
            if (i == rst_at) begin
                reset = 1'b0;
                @(posedge clk);
                #1 reset = 1'b1;
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [6:0] ops [7];
        ops = '{LW, SW, RT, IT, BQ, JL, BAD};
        reset = 1'b0; op = LW; funct3 = 0; funct7b5 = 0; Zero = 0;
        #1 check("FETCH");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("FETCH");
        reset = 1'b1;

        run_instr(LW, 3'b010, 0, 2, -1);
        run_instr(SW, 3'b010, 0, 2, -1);
        run_instr(RT, 3'b000, 1, 2, -1);
        run_instr(IT, 3'b000, 1, 2, -1);
        run_instr(BQ, 3'b000, 0, 1, -1);
        run_instr(BQ, 3'b000, 0, 0, -1);
        run_instr(BQ, 3'b001, 0, 1, -1);
        run_instr(BQ, 3'b001, 0, 0, -1);
        run_instr(JL, 3'b000, 0, 2, -1);
        run_instr(BAD, 3'b000, 0, 2, -1);
        run_instr(LW, 3'b010, 0, 2, 3);
        run_instr(RT, 3'b110, 0, 2, 2);

        for (int n = 0; n < 400; n++) begin
            run_instr(ops[$urandom % 7], 3'($urandom), 1'($urandom),
                      2, ($urandom % 8 == 0) ? int'($urandom % 4) : -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
